// File: rtl/div_operand_prep.sv
// Divider front end: captures an IEEE-754 operand pair, resolves special cases,
// and normalises denormal mantissas one bit per cycle before handing off.
module div_operand_prep (
   input  logic        control,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] DD,
   input  logic [31:0] DS,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_out,
   output logic [9:0]  exp_dd,
   output logic [9:0]  exp_ds,
   output logic [23:0] mant_dd,
   output logic [23:0] mant_ds,
   output logic        special,
   output logic [31:0] special_result,
   output logic        exception,
   output logic        zeroDiv
);

   localparam int unsigned EXP_W  = 10;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned FP_W   = 32;

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t state, state_next;

   logic [EXP_W-1:0]  exp_dd_n, exp_ds_n;
   logic [MANT_W-1:0] mant_dd_n, mant_ds_n;
   logic [FP_W-1:0]   result_n;
   logic              sign_n, special_n, exception_n, zero_div_n;

   // Operand classification
   logic [7:0]  fe_dd, fe_ds;
   logic [22:0] fr_dd, fr_ds;
   logic        dd_zero, ds_zero, dd_inf, ds_inf, dd_nan, ds_nan, invalid, sign_c;
   logic [EXP_W-1:0]  ue_dd, ue_ds;
   logic [MANT_W-1:0] um_dd, um_ds;

   assign fe_dd   = DD[30:23];
   assign fe_ds   = DS[30:23];
   assign fr_dd   = DD[22:0];
   assign fr_ds   = DS[22:0];
   assign dd_zero = (DD[30:0] == 31'd0);
   assign ds_zero = (DS[30:0] == 31'd0);
   assign dd_inf  = (fe_dd == 8'hFF) && (fr_dd == 23'd0);
   assign ds_inf  = (fe_ds == 8'hFF) && (fr_ds == 23'd0);
   assign dd_nan  = (fe_dd == 8'hFF) && (fr_dd != 23'd0);
   assign ds_nan  = (fe_ds == 8'hFF) && (fr_ds != 23'd0);
   assign invalid = dd_nan || ds_nan || (dd_zero && ds_zero) || (dd_inf && ds_inf);
   assign sign_c  = DD[31] ^ DS[31];

   // Denormals take exponent 1 with no hidden bit
   assign ue_dd = (fe_dd != 8'd0) ? {2'b00, fe_dd} : EXP_W'(1);
   assign ue_ds = (fe_ds != 8'd0) ? {2'b00, fe_ds} : EXP_W'(1);
   assign um_dd = {(fe_dd != 8'd0), fr_dd};
   assign um_ds = {(fe_ds != 8'd0), fr_ds};

   always_ff @(posedge control) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      sign_n      = sign_out;
      exp_dd_n    = exp_dd;
      exp_ds_n    = exp_ds;
      mant_dd_n   = mant_dd;
      mant_ds_n   = mant_ds;
      special_n   = special;
      result_n    = special_result;
      exception_n = exception;
      zero_div_n  = zeroDiv;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_n      = sign_c;
               special_n   = 1'b1;
               exception_n = 1'b0;
               zero_div_n  = ds_zero;
               result_n    = '0;
               exp_dd_n    = '0;
               exp_ds_n    = '0;
               mant_dd_n   = '0;
               mant_ds_n   = '0;
               state_next  = DONE;
               if (invalid) begin
                  result_n    = 32'hFFC0_0000;
                  exception_n = 1'b1;
               end else if (ds_zero || dd_inf) begin
                  result_n    = {sign_c, 8'hFF, 23'd0};
                  exception_n = 1'b1;
               end else if (dd_zero || ds_inf) begin
                  result_n    = {sign_c, 31'd0};
               end else begin
                  special_n  = 1'b0;
                  zero_div_n = 1'b0;
                  exp_dd_n   = ue_dd;
                  exp_ds_n   = ue_ds;
                  mant_dd_n  = um_dd;
                  mant_ds_n  = um_ds;
                  state_next = (um_dd[MANT_W-1] && um_ds[MANT_W-1]) ? DONE : NORM;
               end
            end
         end
         NORM: begin
            if (!mant_dd[MANT_W-1]) begin
               mant_dd_n = {mant_dd[MANT_W-2:0], 1'b0};
               exp_dd_n  = exp_dd - EXP_W'(1);
            end
            if (!mant_ds[MANT_W-1]) begin
               mant_ds_n = {mant_ds[MANT_W-2:0], 1'b0};
               exp_ds_n  = exp_ds - EXP_W'(1);
            end
            if (mant_dd_n[MANT_W-1] && mant_ds_n[MANT_W-1]) state_next = DONE;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output registers; handshake flags track the upcoming state
   always_ff @(posedge control) begin
      if (reset) begin
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         sign_out       <= 1'b0;
         exp_dd         <= '0;
         exp_ds         <= '0;
         mant_dd        <= '0;
         mant_ds        <= '0;
         special        <= 1'b0;
         special_result <= '0;
         exception      <= 1'b0;
         zeroDiv        <= 1'b0;
      end else begin
         in_ready       <= (state_next == IDLE);
         out_valid      <= (state_next == DONE);
         sign_out       <= sign_n;
         exp_dd         <= exp_dd_n;
         exp_ds         <= exp_ds_n;
         mant_dd        <= mant_dd_n;
         mant_ds        <= mant_ds_n;
         special        <= special_n;
         special_result <= result_n;
         exception      <= exception_n;
         zeroDiv        <= zero_div_n;
      end
   end

endmodule

// File: doc/div_operand_prep.md
DIV_OPERAND_PREP -- requirements
Module: div_operand_prep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of control.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- control  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept a pair
- DD  in  32  IEEE-754 dividend
- DS  in  32  IEEE-754 divisor
- out_valid  out  1  prepared operands or special result available
- out_ready  in  1  downstream divider accepts the result
- sign_out  out  1  DD[31] xor DS[31]
- exp_dd  out  10  two's-complement effective exponent of DD (biased)
- exp_ds  out  10  two's-complement effective exponent of DS (biased)
- mant_dd  out  24  normalised DD mantissa, bit 23 set
- mant_ds  out  24  normalised DS mantissa, bit 23 set
- special  out  1  special_result is final; divider SHALL be bypassed
- special_result  out  32  IEEE-754 result for special cases
- exception  out  1  special-case exception flag
- zeroDiv  out  1  divisor is zero

Function
REQ-003 FSM states SHALL be IDLE, NORM and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-004 In IDLE with in_valid=1, the block SHALL capture DD and DS, classify them and compute sign_out on that edge, then go to DONE if special=1 or both mantissas are already normalised, otherwise to NORM.
REQ-005 Unpacking: exponent field non-zero -> exp = {2'b00, field}, mant = {1, frac}; field zero and frac non-zero (denormal) -> exp = 1, mant = {0, frac}.
REQ-006 In NORM, each cycle, each operand whose mant[23]=0 SHALL shift its mantissa left by 1 and decrement its exponent by 1; both operands SHALL normalise in parallel.
REQ-007 NORM SHALL go to DONE on the edge at which both mant[23] become 1; the worst case is 23 NORM cycles (frac=1), giving exp = -22 (10'h3EA).
REQ-008 Latency from the accept edge to out_valid SHALL be 1 cycle for normal or special pairs and 1+k cycles for denormal pairs, where k is the larger leading-zero count.
REQ-009 DONE SHALL hold every output stable while out_ready=0, and SHALL return to IDLE on the edge where out_ready=1.
REQ-010 Special classification SHALL follow this priority, first match wins:
- (a) either operand NaN, 0/0, or inf/inf -> 32'hFFC00000, exception=1
- (b) DS zero -> {sign_out, 8'hFF, 23'b0}, exception=1
- (c) DD inf -> {sign_out, 8'hFF, 23'b0}, exception=1
- (d) DD zero or DS inf -> {sign_out, 31'b0}, exception=0
REQ-011 zeroDiv SHALL be 1 whenever DS[30:0]=0, including the 0/0 case; otherwise 0.
REQ-012 When special=1, the mant and exp outputs SHALL be 0 and the NORM state SHALL be skipped.
REQ-013 When special=0, special_result, exception and zeroDiv SHALL be 0.
REQ-014 in_valid while not in IDLE SHALL be ignored, with no capture.
REQ-015 Exponent arithmetic SHALL be 10-bit two's complement with no wrap for any legal input (range -22..254).

Reset
REQ-016 Reset SHALL force IDLE and zero every output except in_ready, which SHALL be 1 on the cycle after reset.
REQ-017 Reset SHALL take priority over every other event, including mid-NORM and DONE with out_ready=1; the in-flight pair SHALL be discarded.

Verification
REQ-018 DD=0x40400000, DS=0x3F800000 -> out_valid 1 cycle after accept; exp_dd=128, mant_dd=0xC00000, exp_ds=127, mant_ds=0x800000, special=0.
REQ-019 DD=0x00000001, DS=0x3F800000 -> 23 NORM cycles; mant_dd=0x800000, exp_dd=10'h3EA, out_valid at accept+24.
REQ-020 DD=0x3F800000, DS=0x80000000 -> special=1, special_result=0xFF800000, exception=1, zeroDiv=1, 1-cycle latency.
REQ-021 DD=0, DS=0 -> special_result=0xFFC00000, exception=1, zeroDiv=1; DD=0x7F800000, DS=0x7F800000 -> 0xFFC00000, zeroDiv=0.
REQ-022 out_ready held 0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs unchanged, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-023 reset asserted on the 10th NORM cycle of the REQ-019 pair -> all outputs 0 and in_ready=1 next cycle; a fresh normal pair then completes in 1 cycle.
